// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller:
// architectural sizes, the hardwired-zero register index and the
// write-back source encoding used by the round-robin arbiter.
package regfile_wb_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file: one pending-write bit per
// register, hazard stall towards issue, sticky error on write-backs to
// registers that were not marked busy, and a registered busy count.
module regfile_scoreboard
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int REG_AW = regfile_wb_ctrl_pkg::REG_AW,
    parameter int NREGS  = regfile_wb_ctrl_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              issue_stall,
    output logic [5:0]        busy_count,
    output logic              wb_err
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [5:0]       count_next;
    logic             issue_accept;

    // Hazard check uses registered busy bits only (no bypass from wb_we)
    always_comb begin
        issue_stall  = issue_valid &
                       (busy[issue_rs1] | busy[issue_rs2] | (issue_we & busy[issue_rd]));
        issue_accept = issue_valid & ~issue_stall;
    end

    // Next busy vector: clear on write-back first, then set on issue so a
    // same-edge set of the same index wins; population count of the result
    always_comb begin
        busy_next = busy;
        if (wb_we) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue_accept && issue_we && (issue_rd != REG_X0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;

        count_next = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            count_next = count_next + 6'(busy_next[i]);
        end
    end

    // Busy state, count and sticky error; error uses the pre-edge busy bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
            wb_err     <= 1'b0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
            wb_err     <= wb_err | (wb_we & ~busy[wb_rd]);
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: round-robin arbitration of the ALU and LSU onto
// the single register-file write port through a one-cycle write stage,
// plus the issue-side busy scoreboard.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int XLEN   = regfile_wb_ctrl_pkg::XLEN,
    parameter int REG_AW = regfile_wb_ctrl_pkg::REG_AW,
    parameter int NREGS  = regfile_wb_ctrl_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    output logic              issue_stall,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [5:0]        busy_count,
    output logic              wb_err
);

    src_e              last_grant;
    logic              alu_xfer;
    logic              lsu_xfer;
    logic              any_xfer;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    // Ready depends only on the other source's valid and last_grant, so a
    // source's ready never loops back through its own valid
    always_comb begin
        alu_ready = rst_n & (~lsu_valid | (last_grant == SRC_LSU));
        lsu_ready = rst_n & (~alu_valid | (last_grant == SRC_ALU));
        alu_xfer  = alu_valid & alu_ready;
        lsu_xfer  = lsu_valid & lsu_ready;
        any_xfer  = alu_xfer | lsu_xfer;
        sel_rd    = lsu_xfer ? lsu_rd   : alu_rd;
        sel_data  = lsu_xfer ? lsu_data : alu_data;
    end

    // Round-robin pointer moves only when a transfer happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_ALU;
        end else if (alu_xfer) begin
            last_grant <= SRC_ALU;
        end else if (lsu_xfer) begin
            last_grant <= SRC_LSU;
        end
    end

    // Registered write stage; x0 transfers are accepted but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= any_xfer & (sel_rd != REG_X0);
            if (any_xfer) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    regfile_scoreboard #(
        .REG_AW (REG_AW),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_we    (issue_we),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .issue_stall (issue_stall),
        .busy_count  (busy_count),
        .wb_err      (wb_err)
    );

endmodule
